serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-to-serial framer that sits directly upstream of the serial sequence detector and drives its 1-bit `in`.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, MSB- or LSB-first.
- Inserts GAP forced-zero cycles after each word so the downstream detector never matches a pattern across a word boundary.

Parameters:
- WIDTH, 8: data word width in bits; legal range is 2 or more.
- LSB_FIRST, 0: bit order. 0 shifts din[WIDTH-1] first; 1 shifts din[0] first.
- GAP, 2: number of forced-zero, not-valid cycles after each word; legal range is 0 or more.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- din  input  WIDTH  parallel word.
- din_valid  input  1  upstream presents a word.
- din_ready  output  1  block can accept a word (combinational: state==IDLE).
- sout  output  1  serial bit; connects to the detector `in`.
- sout_valid  output  1  sout carries a data bit this cycle.
- busy  output  1  state != IDLE.
- frame_done  output  1  one-cycle pulse coincident with the last data bit.

Behaviour:
- Reset:
  - When reset=0, asynchronously force state=IDLE, shift register=0, bit_cnt=0, sout=0, sout_valid=0, frame_done=0.
  - busy=0 and din_ready=1 follow from the IDLE state.
  - Inputs are ignored while reset=0.
- All outputs except din_ready are registered.
- State IDLE:
  - din_ready=1.
  - On an edge with din_valid=1: load din into the shift register, bit_cnt=0, go to SHIFT.
  - In the cycle after that edge: sout = first bit, sout_valid=1. Accept-to-first-bit latency is 1 clock.
- State SHIFT:
  - Each cycle presents the next bit in the selected order; bit_cnt increments each cycle.
  - sout_valid=1 for exactly WIDTH consecutive cycles.
  - frame_done=1 only during the cycle carrying bit WIDTH-1.
  - After the last bit: go to GAP if GAP>0, otherwise go to IDLE.
- State GAP:
  - sout=0, sout_valid=0, busy=1 for exactly GAP cycles, then go to IDLE.
- IDLE output levels: sout=0, sout_valid=0. sout is never left at the last data bit.
- Throughput: one word per WIDTH+GAP+1 cycles. The extra cycle is the mandatory IDLE acceptance cycle; no acceptance happens during SHIFT or GAP.
- Handshake:
  - din_valid while din_ready=0 is ignored; the word is not captured and must be held by upstream.
  - Changes on din after acceptance have no effect on the word being shifted.
- Counter width: $clog2(max(WIDTH,GAP)) bits, minimum 1. bit_cnt is compared against WIDTH-1 and the gap counter against GAP-1; neither wraps.
- Reset mid-frame: output goes immediately to sout=0, sout_valid=0. The partial word is discarded, no frame_done is issued, and the next accepted word starts from bit 0.
- Illegal state encodings recover to IDLE on the next edge with outputs zero.

Decomposition:
- Shared package serial_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2;
  - the default WIDTH and GAP constants, shared with the detector bench.
- No sub-module. The shift register, counter and FSM stay in one module; a separate counter module adds nothing.

Test Plan:
- MSB-first framing (WIDTH=8, GAP=2, LSB_FIRST=0): din=8'hB6 accepted at edge 0.
  - sout=1,0,1,1,0,1,1,0 on cycles 1..8 with sout_valid=1.
  - frame_done=1 on cycle 8 only.
  - Cycles 9-10: sout=0, sout_valid=0, busy=1.
  - din_ready=1 on cycle 11.
- LSB-first framing (LSB_FIRST=1): din=8'h01 gives sout=1 then seven 0s.
- Back-to-back words (din_valid held at 1, words 8'hFF then 8'h00):
  - second acceptance occurs exactly 11 cycles after the first;
  - second word's first bit appears on cycle 12.
- Chained with the detector: feed 8'h03 then 8'h80.
  - Detector sees 11 only inside the first word.
  - No match is formed across the 8'h03 to 8'h80 boundary; the gap zeros separate the two words.
- Busy and GAP=0 checks:
  - Toggle din and din_valid during SHIFT: the shifted bits equal the originally accepted word.
  - With GAP=0, the next word's first bit appears 2 cycles after the previous frame_done.
- Reset mid-frame: drive reset=0 mid-cycle during bit 4.
  - sout and sout_valid go to 0 before the next edge; no frame_done is issued.
  - After release, din_ready=1; the next word 8'hA5 shifts out in full from bit 7.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared encodings and defaults for the serial framer/detector pair
package serial_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_GAP   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_GAP   = ST_GAP
  } state_t;

  // One counter serves both the bit index and the gap length.
  function automatic int cnt_width(input int w, input int g);
    int m;
    m = (w > g) ? w : g;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-to-serial framer with forced-zero inter-word gap
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0,
  parameter int GAP       = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_W = cnt_width(WIDTH, GAP);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] BIT_PENULT = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  // sout is loaded with the next bit one edge ahead, so the register always holds
  // the words remaining bits with the head already consumed.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (din_valid) begin
          state_d      = S_SHIFT;
          shreg_d      = drop_head(din);
          cnt_d        = '0;
          sout_d       = head_bit(din);
          sout_valid_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = '0;
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          sout_d       = head_bit(shreg_q);
          shreg_d      = drop_head(shreg_q);
          sout_valid_d = 1'b1;
          frame_done_d = (cnt_q == BIT_PENULT);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign din_ready  = (state_q == S_IDLE);
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - randomized and directed bench for serial_frame_tx
module tb_serial_frame_tx;
  import serial_pkg::*;

  localparam int W = DEFAULT_WIDTH;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din_s   [N];
  logic         dv_s    [N];
  logic         ready_w [N];
  logic         sout_w  [N];
  logic         sv_w    [N];
  logic         busy_w  [N];
  logic         fd_w    [N];

  always #5 clk = ~clk;

  // Instance 0: MSB-first GAP=2, 1: LSB-first GAP=2, 2: MSB-first GAP=0.
  for (genvar k = 0; k < N; k++) begin : g_dut
    serial_frame_tx #(
      .WIDTH    (W),
      .LSB_FIRST(k == 1),
      .GAP      ((k == 2) ? 0 : DEFAULT_GAP)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .din       (din_s[k]),
      .din_valid (dv_s[k]),
      .din_ready (ready_w[k]),
      .sout      (sout_w[k]),
      .sout_valid(sv_w[k]),
      .busy      (busy_w[k]),
      .frame_done(fd_w[k])
    );
  end

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [W-1:0] word_m [N];
  int           pos_m  [N];
  int           acc_n  [N];
  int           acc_t0 [N];
  int           acc_t1 [N];
  bit           collect = 1'b0;
  logic         prev_bit = 1'b0;
  int           pairs = 0;

  function automatic int gap_of(input int k);
    return (k == 2) ? 0 : DEFAULT_GAP;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // The model: pos counts cycles since acceptance; 1..W carry bits, then GAP zero cycles.
  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      int   p;
      logic ev, ef, eb, ebusy;
      p     = pos_m[k];
      ebusy = (p != 0);
      ev    = (p >= 1) && (p <= W);
      ef    = (p == W);
      eb    = 1'b0;
      if (ev) eb = (k == 1) ? word_m[k][p-1] : word_m[k][W-p];
      check_eq($sformatf("d%0d_ready", k), 32'(ready_w[k]), 32'(!ebusy));
      check_eq($sformatf("d%0d_busy", k),  32'(busy_w[k]),  32'(ebusy));
      check_eq($sformatf("d%0d_valid", k), 32'(sv_w[k]),    32'(ev));
      check_eq($sformatf("d%0d_sout", k),  32'(sout_w[k]),  32'(eb));
      check_eq($sformatf("d%0d_done", k),  32'(fd_w[k]),    32'(ef));
    end
  endtask

  task automatic tick();
    for (int k = 0; k < N; k++) begin
      if (rst_n && dv_s[k] && ready_w[k]) begin
        if (acc_n[k] == 0) acc_t0[k] = cyc;
        else if (acc_n[k] == 1) acc_t1[k] = cyc;
        acc_n[k]++;
      end
      if (!rst_n) pos_m[k] = 0;
      else if (pos_m[k] == 0) begin
        if (dv_s[k]) begin
          pos_m[k]  = 1;
          word_m[k] = din_s[k];
        end
      end else if (pos_m[k] == W + gap_of(k)) pos_m[k] = 0;
      else pos_m[k]++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_all();
    if (collect) begin
      if (prev_bit && sout_w[0]) pairs++;
      prev_bit = sout_w[0];
    end
  endtask

  task automatic drive_all(input logic [W-1:0] d, input logic v);
    for (int k = 0; k < N; k++) begin
      din_s[k] = d;
      dv_s[k]  = v;
    end
  endtask

  task automatic send_word(input logic [W-1:0] d);
    drive_all(d, 1'b1);
    tick();
    drive_all(W'($urandom), 1'b0);
    repeat (W + DEFAULT_GAP + 2) tick();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      pos_m[k]  = 0;
      word_m[k] = '0;
      acc_n[k]  = 0;
    end
    rst_n = 1'b0;
    drive_all(8'hC3, 1'b1);
    @(negedge clk);
    check_all();
    tick();
    tick();
    rst_n = 1'b1;

    send_word(8'hB6);
    send_word(8'h01);

    for (int k = 0; k < N; k++) acc_n[k] = 0;
    drive_all(8'hFF, 1'b1);
    tick();
    drive_all(8'h00, 1'b1);
    repeat (24) tick();
    for (int k = 0; k < N; k += 2) begin
      check_eq($sformatf("d%0d_accepts", k), 32'(acc_n[k] >= 2), 32'd1);
      check_eq($sformatf("d%0d_accept_spacing", k), 32'(acc_t1[k] - acc_t0[k]),
               32'(W + gap_of(k) + 1));
    end
    drive_all(8'h00, 1'b0);
    repeat (12) tick();

    drive_all(8'h03, 1'b1);
    tick();
    drive_all(8'h80, 1'b1);
    collect  = 1'b1;
    prev_bit = 1'b0;
    pairs    = 0;
    repeat (11) tick();
    drive_all(8'h00, 1'b0);
    repeat (12) tick();
    collect = 1'b0;
    check_eq("detector_11_pairs", 32'(pairs), 32'd1);

    repeat (400) begin
      for (int k = 0; k < N; k++) begin
        din_s[k] = W'($urandom);
        dv_s[k]  = ($urandom_range(0, 2) != 0);
      end
      tick();
    end
    drive_all(8'h00, 1'b0);
    repeat (12) tick();

    drive_all(8'h3C, 1'b1);
    tick();
    drive_all(8'hFF, 1'b1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      check_eq($sformatf("d%0d_rst_sout", k),  32'(sout_w[k]),  32'd0);
      check_eq($sformatf("d%0d_rst_valid", k), 32'(sv_w[k]),    32'd0);
      check_eq($sformatf("d%0d_rst_done", k),  32'(fd_w[k]),    32'd0);
      check_eq($sformatf("d%0d_rst_busy", k),  32'(busy_w[k]),  32'd0);
      check_eq($sformatf("d%0d_rst_ready", k), 32'(ready_w[k]), 32'd1);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    send_word(8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
